// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: two-stage ALU issue/collect controller; define ALU_ISSUE_BNE_EN to add bne branch resolution
module alu_issue_ctrl #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op_main,
  input  logic [2:0]       funct3,
  input  logic             funct7_5,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_take_branch,
  output logic             out_illegal,
  output logic [CNT_W-1:0] op_count
);
  logic       s1_valid, s1_ill, s1_br, s1_bne;
  logic       accept, move, take, dec_bne;
  logic [3:0] r_ctrl, b_ctrl, dec_ctrl;
  logic [3:0] rf;
  assign rf = {funct7_5, funct3};
  assign r_ctrl = rf == 4'b0000 ? 4'b0010 :
                  rf == 4'b1000 ? 4'b0110 :
                  rf == 4'b0111 ? 4'b0000 :
                  rf == 4'b0110 ? 4'b0001 :
                  rf == 4'b1100 ? 4'b1100 : 4'b1111;
`ifdef ALU_ISSUE_BNE_EN
  assign b_ctrl = funct3[2:1] == 2'b00 ? 4'b0110 : 4'b1111;
  assign dec_bne = funct3 == 3'b001;
`else
  assign b_ctrl = 4'b0110;
  assign dec_bne = 1'b0;
`endif
  assign dec_ctrl = alu_op_main == 2'b00 ? 4'b0010 :
                    alu_op_main == 2'b01 ? b_ctrl :
                    alu_op_main == 2'b10 ? r_ctrl : 4'b1111;
  assign in_ready = !s1_valid || !out_valid || out_ready;
  assign accept = in_valid && in_ready;
  assign move = s1_valid && (!out_valid || out_ready);
  assign take = s1_br && !s1_ill && (s1_bne ? !alu_zero : alu_zero);
  always_ff @(posedge clk)
    if (reset) begin
      s1_valid        <= 1'b0;
      s1_ill          <= 1'b0;
      s1_br           <= 1'b0;
      s1_bne          <= 1'b0;
      alu_a           <= '0;
      alu_b           <= '0;
      alu_ctrl        <= 4'b0000;
      out_valid       <= 1'b0;
      out_result      <= '0;
      out_zero        <= 1'b0;
      out_take_branch <= 1'b0;
      out_illegal     <= 1'b0;
      op_count        <= '0;
    end else begin
      s1_valid  <= accept || (s1_valid && !move);
      out_valid <= move || (out_valid && !out_ready);
      if (accept) begin
        alu_a    <= in_a;
        alu_b    <= in_b;
        alu_ctrl <= dec_ctrl;
        s1_ill   <= dec_ctrl == 4'b1111;
        s1_br    <= alu_op_main == 2'b01;
        s1_bne   <= dec_bne;
      end
      if (move) begin
        out_result      <= alu_result;
        out_zero        <= alu_zero;
        out_take_branch <= take;
        out_illegal     <= s1_ill;
      end
      if (out_valid && out_ready) op_count <= op_count + CNT_W'(1);
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: randomized and directed checks of alu_issue_ctrl against a queue-based reference model
module tb_alu_issue_ctrl;
  localparam int W = 64;
  localparam int CW = 4;
  typedef enum {K_ADD, K_SUB, K_AND, K_OR, K_NOR, K_BEQ, K_BNE, K_ILL} kind_e;
  typedef struct {
    logic [3:0]   ctrl;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         zero;
    logic         take;
    logic         ill;
  } op_t;
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic          funct7_5 = 1'b0;
  logic [1:0]    alu_op_main = 2'b00;
  logic [2:0]    funct3 = 3'b000;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic [W-1:0]  alu_a, alu_b, alu_result, out_result;
  logic [3:0]    alu_ctrl;
  logic          in_ready, alu_zero, out_valid, out_zero, out_take_branch, out_illegal;
  logic [CW-1:0] op_count;
  int            checks = 0;
  int            fails = 0;
  op_t           q1[$];
  op_t           q2[$];
  logic [CW-1:0] exp_cnt = '0;
  always #5 clk = ~clk;
  alu_issue_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op_main(alu_op_main), .funct3(funct3), .funct7_5(funct7_5),
    .in_a(in_a), .in_b(in_b), .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero), .out_take_branch(out_take_branch),
    .out_illegal(out_illegal), .op_count(op_count)
  );
  always_comb begin
    case (alu_ctrl)
      4'b0010: alu_result = alu_a + alu_b;
      4'b0110: alu_result = alu_a - alu_b;
      4'b0000: alu_result = alu_a & alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      4'b1100: alu_result = ~(alu_a | alu_b);
      default: alu_result = '0;
    endcase
  end
  assign alu_zero = alu_result == '0;
  function automatic op_t model(input logic [1:0] m, input logic [2:0] f3, input logic f7,
                                input logic [W-1:0] a, input logic [W-1:0] b);
    op_t o;
    kind_e k;
    logic [3:0] r;
    r = {f7, f3};
    k = K_ILL;
    if (m == 2'b00) k = K_ADD;
    else if (m == 2'b10)
      k = r == 4'b0000 ? K_ADD : r == 4'b1000 ? K_SUB : r == 4'b0111 ? K_AND :
          r == 4'b0110 ? K_OR : r == 4'b1100 ? K_NOR : K_ILL;
    else if (m == 2'b01)
`ifdef ALU_ISSUE_BNE_EN
      k = f3 == 3'b000 ? K_BEQ : f3 == 3'b001 ? K_BNE : K_ILL;
`else
      k = K_BEQ;
`endif
    o.a = a;
    o.b = b;
    case (k)
      K_ADD: begin o.ctrl = 4'b0010; o.res = a + b; end
      K_AND: begin o.ctrl = 4'b0000; o.res = a & b; end
      K_OR:  begin o.ctrl = 4'b0001; o.res = a | b; end
      K_NOR: begin o.ctrl = 4'b1100; o.res = ~(a | b); end
      K_ILL: begin o.ctrl = 4'b1111; o.res = '0; end
      default: begin o.ctrl = 4'b0110; o.res = a - b; end
    endcase
    o.zero = o.res == '0;
    o.ill = k == K_ILL;
    o.take = (k == K_BEQ && a == b) || (k == K_BNE && a != b);
    return o;
  endfunction
  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input logic iv, input logic [1:0] m, input logic [2:0] f3, input logic f7,
                     input logic [W-1:0] a, input logic [W-1:0] b, input logic ordy, output logic acc);
    logic rdy, hs, mv;
    in_valid = iv;
    alu_op_main = m;
    funct3 = f3;
    funct7_5 = f7;
    in_a = a;
    in_b = b;
    out_ready = ordy;
    @(negedge clk);
    rdy = q1.size() == 0 || q2.size() == 0 || ordy;
    chk("in_ready", W'(in_ready), W'(rdy));
    chk("out_valid", W'(out_valid), W'(q2.size() != 0));
    chk("op_count", W'(op_count), W'(exp_cnt));
    if (q1.size() != 0) begin
      chk("alu_ctrl", W'(alu_ctrl), W'(q1[0].ctrl));
      chk("alu_a", alu_a, q1[0].a);
      chk("alu_b", alu_b, q1[0].b);
    end
    if (q2.size() != 0) begin
      chk("out_result", out_result, q2[0].res);
      chk("out_zero", W'(out_zero), W'(q2[0].zero));
      chk("out_take_branch", W'(out_take_branch), W'(q2[0].take));
      chk("out_illegal", W'(out_illegal), W'(q2[0].ill));
    end
    hs = q2.size() != 0 && ordy;
    mv = q1.size() != 0 && (q2.size() == 0 || ordy);
    acc = iv && rdy;
    @(posedge clk);
    if (hs) begin
      void'(q2.pop_front());
      exp_cnt++;
    end
    if (mv) q2.push_back(q1.pop_front());
    if (acc) q1.push_back(model(m, f3, f7, a, b));
    #1;
  endtask
  task automatic do_reset(input logic iv, input logic ordy);
    reset = 1'b1;
    in_valid = iv;
    out_ready = ordy;
    @(posedge clk);
    #1;
    reset = 1'b0;
    q1.delete();
    q2.delete();
    exp_cnt = '0;
  endtask
  task automatic reset_checks(input string tag);
    chk({tag, "_in_ready"}, W'(in_ready), W'(1));
    chk({tag, "_out_valid"}, W'(out_valid), W'(0));
    chk({tag, "_alu_a"}, alu_a, '0);
    chk({tag, "_alu_b"}, alu_b, '0);
    chk({tag, "_alu_ctrl"}, W'(alu_ctrl), W'(0));
    chk({tag, "_out_result"}, out_result, '0);
    chk({tag, "_out_zero"}, W'(out_zero), W'(0));
    chk({tag, "_out_take"}, W'(out_take_branch), W'(0));
    chk({tag, "_out_illegal"}, W'(out_illegal), W'(0));
    chk({tag, "_op_count"}, W'(op_count), W'(0));
  endtask
  task automatic run(input logic [1:0] m, input logic [2:0] f3, input logic f7,
                     input logic [W-1:0] a, input logic [W-1:0] b);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < 8 && !acc; i++) cyc(1'b1, m, f3, f7, a, b, 1'b1, acc);
    repeat (3) cyc(1'b0, 2'b00, 3'b000, 1'b0, '0, '0, 1'b1, acc);
  endtask
  initial begin
    logic acc;
    logic [1:0] m;
    logic [2:0] f3;
    logic f7, iv, ordy;
    logic [W-1:0] a, b;
    logic [3:0] bp_f [4];
    int idx, n;
    bp_f[0] = 4'b0111;
    bp_f[1] = 4'b0110;
    bp_f[2] = 4'b1100;
    bp_f[3] = 4'b1000;
    do_reset(1'b0, 1'b0);
    reset_checks("por");
    run(2'b10, 3'b000, 1'b0, 64'd5, 64'd7);
    chk("add_result", out_result, 64'd12);
    chk("add_zero", W'(out_zero), W'(0));
    chk("add_count", W'(op_count), W'(1));
    run(2'b01, 3'b000, 1'b0, 64'h1234, 64'h1234);
    chk("beq_eq_take", W'(out_take_branch), W'(1));
    chk("beq_eq_zero", W'(out_zero), W'(1));
    chk("beq_eq_result", out_result, '0);
    run(2'b01, 3'b000, 1'b0, 64'h1234, 64'h1235);
    chk("beq_ne_take", W'(out_take_branch), W'(0));
    run(2'b01, 3'b001, 1'b0, 64'h1234, 64'h1234);
    run(2'b01, 3'b001, 1'b0, 64'h1234, 64'h1235);
    run(2'b01, 3'b101, 1'b0, 64'h99, 64'h99);
    run(2'b11, 3'b000, 1'b0, 64'h1234, 64'h1234);
    chk("ill_flag", W'(out_illegal), W'(1));
    chk("ill_result", out_result, '0);
    chk("ill_zero", W'(out_zero), W'(1));
    chk("ill_take", W'(out_take_branch), W'(0));
    run(2'b10, 3'b001, 1'b0, 64'h7, 64'h3);
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    idx = 0;
    for (int c = 0; c < 20 && idx < 4; c++) begin
      cyc(1'b1, 2'b10, bp_f[idx][2:0], bp_f[idx][3], a, b, c >= 3, acc);
      if (acc) idx++;
    end
    chk("bp_all_accepted", W'(idx), W'(4));
    repeat (4) cyc(1'b0, 2'b00, 3'b000, 1'b0, '0, '0, 1'b1, acc);
    for (int i = 0; i < 400; i++) begin
      m = 2'($urandom);
      f3 = 3'($urandom);
      f7 = 1'($urandom);
      a = {$urandom, $urandom};
      b = ($urandom_range(0, 1) == 0) ? a : {$urandom, $urandom};
      iv = $urandom_range(0, 3) != 0;
      ordy = $urandom_range(0, 2) != 0;
      cyc(iv, m, f3, f7, a, b, ordy, acc);
    end
    repeat (4) cyc(1'b0, 2'b00, 3'b000, 1'b0, '0, '0, 1'b1, acc);
    n = 0;
    while (exp_cnt != 4'd15 && n < 100) begin
      cyc(1'b1, 2'b00, 3'b000, 1'b0, 64'(n), 64'd1, 1'b1, acc);
      n++;
    end
    chk("wrap_pre", W'(op_count), W'(15));
    cyc(1'b1, 2'b00, 3'b000, 1'b0, 64'd3, 64'd4, 1'b1, acc);
    chk("wrap_post", W'(op_count), W'(0));
    repeat (3) cyc(1'b1, 2'b10, 3'b000, 1'b0, 64'hAA, 64'h55, 1'b0, acc);
    do_reset(1'b1, 1'b1);
    reset_checks("mid");
    repeat (5) cyc(1'b0, 2'b00, 3'b000, 1'b0, '0, '0, 1'b1, acc);
    chk("mid_no_stale", W'(out_valid), W'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Two-stage issue/collect controller sitting in front of the 64-bit ALU. It accepts decoded-instruction fields and operands over a valid/ready handshake and translates the main-control ALUOp plus funct fields into the ALU's 4-bit operation code. It drives the ALU from a registered issue stage, then captures Result/ZERO into an output register with branch resolution for the downstream writeback/PC logic.

## Interface

- WIDTH, 64, operand/result width; must match the ALU.
- CNT_W, 32, width of the retired-operation counter.

- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream holds a valid request.
- in_ready  out  1  controller can accept this cycle.
- alu_op_main  in  2  main-control ALUOp: 00 load/store, 01 branch, 10 R-type, 11 reserved.
- funct3  in  3  instruction funct3.
- funct7_5  in  1  instruction bit 30.
- in_a, in_b  in  WIDTH  operands.
- alu_a, alu_b  out  WIDTH  operands driven to the ALU.
- alu_ctrl  out  4  ALU operation code.
- alu_result  in  WIDTH  ALU Result, combinational from alu_a/alu_b/alu_ctrl.
- alu_zero  in  1  ALU ZERO flag.
- out_valid  out  1  output register holds a result.
- out_ready  in  1  downstream accepts the result.
- out_result  out  WIDTH  captured result.
- out_zero  out  1  captured ZERO.
- out_take_branch  out  1  branch resolved as taken.
- out_illegal  out  1  op did not decode.
- op_count  out  CNT_W  count of results handed off.

## Operation

- Decode, on accept:
  - alu_op_main 00 gives 0010 (add).
  - 01 gives 0110 (sub).
  - 10 with {funct7_5,funct3}:
    - 0_000 gives 0010.
    - 1_000 gives 0110.
    - 0_111 gives 0000 (and).
    - 0_110 gives 0001 (or).
    - 1_100 gives 1100 (nor).
  - Any other combination, including alu_op_main 11: alu_ctrl 1111, illegal flag set. The ALU returns 0 for this code, so the captured result is 0 and ZERO is 1.
- Stage 1 (issue register): captures in_a, in_b, decoded ctrl, illegal flag, is_branch (alu_op_main==01) and funct3 on in_valid && in_ready. alu_a/alu_b/alu_ctrl come directly from this register.
- Stage 2 (output register): captures alu_result, alu_zero, illegal flag and branch decision when s1_valid and stage 2 is empty or draining. s1_valid clears on that move unless a new request is accepted in the same cycle.
- Handshake rules:
  - in_ready = !s1_valid || !out_valid || out_ready.
  - out_valid stays high and the out_* fields stay stable until out_valid && out_ready.
- Branch resolution: out_take_branch = is_branch && zero. It is 0 for non-branch and illegal ops.
- op_count increments by 1 on each out_valid && out_ready and wraps from all-ones to 0.
- Boundary cases:
  - Simultaneous output handshake, stage-1-to-stage-2 move and new accept in one cycle: all three occur.
  - Backpressure with both stages full: in_ready=0 and nothing is overwritten.
  - Reset mid-operation: in-flight ops are discarded and never appear on the output.

## Timing

- Reset values:
  - in_ready=1, out_valid=0.
  - alu_a=alu_b=0, alu_ctrl=0000.
  - out_result=0, out_zero=0, out_take_branch=0, out_illegal=0.
  - op_count=0.
- Latency: request accepted at edge N; ALU is driven during cycle N..N+1; out_valid rises after edge N+1 and the result is visible in cycle N+1.
- Throughput: one op per cycle while out_ready is held high.
- The ALU path is combinational within one cycle between the stage 1 and stage 2 registers.

## Configuration

- ALU_ISSUE_BNE_EN:
  - Defined: branches with funct3=001 resolve as taken when ZERO=0 (bne). Branches with funct3=000 keep beq behaviour. Other branch funct3 values are illegal.
  - Undefined: funct3 is ignored for alu_op_main 01, and every branch is treated as beq.

## Test plan

- R-type add, out_ready=1: a=5, b=7, {funct7_5,funct3}=0_000 -> alu_ctrl=0010, out_result=12, out_zero=0, out_valid 2 cycles after accept, op_count=1.
- Branch equal: alu_op_main=01, a=b=0x1234 -> alu_ctrl=0110, out_result=0, out_zero=1, out_take_branch=1. Repeat with b=0x1235 -> out_take_branch=0. Repeat with ALU_ISSUE_BNE_EN defined and funct3=001 -> taken only for the unequal pair.
- Back-to-back stream under backpressure: 4 ops (and, or, nor, sub) with out_ready=0 for 3 cycles -> in_ready=0 after 2 accepts. Results emerge in order: a&b, a|b, ~(a|b), a-b. No loss or duplication.
- Illegal decode: alu_op_main=11 -> out_illegal=1, out_result=0, out_zero=1, out_take_branch=0.
- Reset mid-flight: assert reset with both stages valid -> next cycle out_valid=0, in_ready=1, op_count=0, and no stale result ever appears.
- Counter wrap: preload via 2^CNT_W handshakes (CNT_W=4 in test) -> op_count goes 15 -> 0.
